// File: rtl/snn_pkg.sv
// Shared definitions for the line buffer, window generator and PE array:
// frame FSM encoding and the lane/row/col slice-index helpers.
package snn_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam int unsigned ROWS = 3;
  localparam int unsigned COLS = 3;

  // Pixel index of (lane, row) inside a line-buffer column word.
  function automatic int unsigned col_idx(input int unsigned lane, input int unsigned row);
    return ROWS * lane + row;
  endfunction

  // Pixel index of (lane, row, col) inside a window word.
  function automatic int unsigned win_idx(input int unsigned lane, input int unsigned row,
                                          input int unsigned col);
    return ROWS * COLS * lane + COLS * row + col;
  endfunction

endpackage

// File: rtl/window_lane.sv
// One lane of the 3x3 window: three column registers shifted left on SHIFT;
// c0 is the leftmost (oldest) column of the window.
module window_lane
  import snn_pkg::*;
#(
  parameter int unsigned DW = 16
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            SHIFT,
  input  logic [3*DW-1:0] COL,
  output logic [9*DW-1:0] WIN
);

  logic [3*DW-1:0] c0;
  logic [3*DW-1:0] c1;
  logic [3*DW-1:0] c2;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      c0 <= '0;
      c1 <= '0;
      c2 <= '0;
    end else if (SHIFT) begin
      c0 <= c1;
      c1 <= c2;
      c2 <= COL;
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    assign WIN[win_idx(0, r, 0)*DW +: DW] = c0[col_idx(0, r)*DW +: DW];
    assign WIN[win_idx(0, r, 1)*DW +: DW] = c1[col_idx(0, r)*DW +: DW];
    assign WIN[win_idx(0, r, 2)*DW +: DW] = c2[col_idx(0, r)*DW +: DW];
  end

endmodule

// File: rtl/window3x3.sv
// 3x3 sliding-window generator behind the 3-row line buffer: aligns the column
// strobe, tracks frame position, emits valid-only windows and a frame-done pulse.
module window3x3
  import snn_pkg::*;
#(
  parameter int unsigned LANES = 4,
  parameter int unsigned DW    = 16,
  parameter int unsigned AW    = 5
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  IN_VALID,
  input  logic [LANES*3*DW-1:0] COL_IN,
  input  logic [AW-1:0]         WIDTH_M1,
  input  logic [AW-1:0]         HEIGHT_M1,
  output logic                  OUT_VALID,
  output logic [LANES*9*DW-1:0] WIN,
  output logic                  FRAME_DONE
);

  logic          col_vld;
  logic [1:0]    state_q;
  logic [1:0]    state_d;
  logic [AW-1:0] col_q;
  logic [AW-1:0] col_d;
  logic [AW-1:0] row_q;
  logic [AW-1:0] row_d;
  logic          out_valid_d;
  logic          frame_done_d;
  logic          last_px;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    window_lane #(.DW(DW)) u_lane (
      .CLK  (CLK),
      .RST  (RST),
      .SHIFT(col_vld),
      .COL  (COL_IN[col_idx(k, 0)*DW +: 3*DW]),
      .WIN  (WIN[win_idx(k, 0, 0)*DW +: 9*DW])
    );
  end

  // Next-state, position counters and output decode; windows use pre-increment position.
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    out_valid_d  = 1'b0;
    frame_done_d = (state_q == ST_DONE);
    last_px      = col_vld && (col_q == WIDTH_M1) && (row_q == HEIGHT_M1);

    if (col_vld) begin
      out_valid_d = (row_q >= AW'(2)) && (col_q >= AW'(2));
      if (col_q == WIDTH_M1) begin
        col_d = '0;
        row_d = (row_q == HEIGHT_M1) ? '0 : row_q + AW'(1);
      end else begin
        col_d = col_q + AW'(1);
      end
    end

    case (state_q)
      ST_IDLE:   if (col_vld) state_d = last_px ? ST_DONE : ST_ACTIVE;
      ST_ACTIVE: if (last_px) state_d = ST_DONE;
      ST_DONE:   state_d = col_vld ? (last_px ? ST_DONE : ST_ACTIVE) : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      col_vld    <= 1'b0;
      col_q      <= '0;
      row_q      <= '0;
      OUT_VALID  <= 1'b0;
      FRAME_DONE <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_vld    <= IN_VALID;
      col_q      <= col_d;
      row_q      <= row_d;
      OUT_VALID  <= out_valid_d;
      FRAME_DONE <= frame_done_d;
    end
  end

endmodule
